alu_issue: RTL and testbench
============================

# alu_issue

Sequencing stage directly upstream of the combinational `alu`. It accepts operation requests (opcode plus two operands) over a valid/ready handshake and registers them onto the ALU inputs. One cycle later it captures the ALU result and flags into a DEPTH-entry result FIFO, which it presents downstream over a second valid/ready handshake. It also screens divide/modulo-by-zero and keeps a sticky overflow status bit.

## Interface
- WIDTH, 32, operand/result width; legal values 8, 16, 32.
- DEPTH, 4, result FIFO entries; power of two, at least 2.

- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- in_valid  input  1  request valid.
- in_ready  output  1  stage can accept a request.
- in_opcode  input  4  ALU opcode: 0000 AND, 0001 OR, 0010 XOR, 0011 NOR, 0100 NAND, 0101 NOT, 0110 ADD, 0111 SUB, 1000 SLT, 1001 MULT, 1010 DIV, 1011 MOD, 1100 SLA, 1101 SRA; 1110/1111 are the ALU default.
- in_a, in_b  input  WIDTH  signed operands.
- alu_a, alu_b  output  WIDTH  registered operands to the ALU.
- alu_opcode  output  4  registered opcode to the ALU.
- alu_result  input  WIDTH  ALU result.
- alu_zero, alu_negative, alu_carryout, alu_overflow  input  1  ALU flags.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  downstream accepts head.
- out_result  output  WIDTH  head result.
- out_flags  output  4  head flags {overflow, carryout, negative, zero}.
- out_err  output  1  head was a divide/modulo by zero.
- sticky_ovf  output  1  set by any captured overflow.
- clr_sticky  input  1  synchronous clear of sticky_ovf.

## Operation
- FSM with two states:
  - IDLE: in_ready = (count < DEPTH). On in_valid && in_ready, load alu_a/alu_b/alu_opcode from the inputs and go to EXEC.
  - EXEC: in_ready = 0. The ALU settles combinationally during this cycle. At the closing edge, push one entry into the FIFO and return to IDLE.
- Throughput: one operation per 2 cycles maximum.
- Push entry: {alu_result, flags, err=0}.
- Divide-by-zero: if alu_opcode is 1010 or 1011 and alu_b == 0, push {result=0, flags=4'b0001, err=1} instead; the ALU output is ignored.
- FIFO:
  - Circular buffer; read and write pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0; count runs 0..DEPTH.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Overflow is impossible: IDLE only accepts a request when count < DEPTH.
- out_valid = (count != 0). When empty, out_result, out_flags and out_err read 0.
- sticky_ovf:
  - Set on a push whose overflow flag is 1.
  - Cleared by clr_sticky.
  - Set wins when set and clear coincide.
- Operands pass unmodified. Width and sign semantics belong to the ALU.

## Timing
- Reset values: state IDLE; alu_a = 0, alu_b = 0, alu_opcode = 0; pointers and count 0; out_valid 0; out_result 0, out_flags 0, out_err 0; sticky_ovf 0. in_ready is 1 in the first cycle after reset deasserts.
- Latency: request accepted at edge N → ALU inputs valid after N → entry pushed at N+1 → out_valid high after N+1 if the FIFO was empty (2 cycles from acceptance).
- Downstream stall: with out_ready low, in_ready drops once count reaches DEPTH, and in_valid is then ignored.
- Reset asserted mid-EXEC: the in-flight op is discarded and nothing is pushed. FIFO contents are lost.
- Handshake rules:
  - in_ready and out_valid depend only on registered state; there is no combinational path from in_valid or out_ready.
  - A request held with in_valid while in_ready is low must not be consumed.

## Test plan
- ADD overflow: opcode 0110, a = 32'h7FFFFFFF, b = 1 (WIDTH 32) → out_result = 32'h80000000, out_flags[3] = 1, out_flags[1] = 1, sticky_ovf = 1 two cycles after acceptance; clr_sticky pulse → sticky_ovf = 0.
- Divide by zero: opcode 1010, a = 10, b = 0 → out_result = 0, out_flags = 4'b0001, out_err = 1; then opcode 1010, a = 10, b = 5 → out_result = 2, out_err = 0.
- Backpressure: out_ready = 0, issue 5 requests (SUB 5−4) → first 4 accepted, in_ready = 0 while count = 4; raise out_ready → 4 results of 1 drain in order, 5th request accepted.
- Concurrent push and pop: hold count = 2, out_ready = 1, push during a pop cycle → count stays 2, pointers wrap correctly across more than DEPTH ops, results in issue order (MULT 4×2 = 8, MOD 4%3 = 1, SLT 3<10 = 1).
- Reset mid-EXEC: accept AND 1&0, assert reset during EXEC → out_valid = 0, alu_opcode = 0, in_ready = 1 after release; no stale entry appears.
- WIDTH = 8 regression: ADD 127 + 1 → out_result = 8'h80, overflow = 1.

Source files
------------

// File: rtl/alu_issue.sv
// Issue stage in front of a combinational ALU: registers one request onto the ALU
// inputs, captures the settled result a cycle later into a small result FIFO.
module alu_issue #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_opcode,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_opcode,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   input  logic             alu_negative,
   input  logic             alu_carryout,
   input  logic             alu_overflow,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [3:0]       out_flags,
   output logic             out_err,
   output logic             sticky_ovf,
   input  logic             clr_sticky
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
   localparam logic [3:0] OP_DIV = 4'b1010;
   localparam logic [3:0] OP_MOD = 4'b1011;

   typedef enum logic {
      IDLE = 1'b0,
      EXEC = 1'b1
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] a_reg, b_reg;
   logic [3:0]       op_reg;
   logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             sticky_reg;

   logic [WIDTH-1:0] res_mem  [DEPTH];
   logic [3:0]       flag_mem [DEPTH];
   logic             err_mem  [DEPTH];

   logic             accept, push, pop, div_zero;
   logic [WIDTH-1:0] push_result;
   logic [3:0]       push_flags;

   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      push       = 1'b0;
      in_ready   = 1'b0;
      case (state_reg)
         IDLE: begin
            in_ready = (count_reg < FULL_COUNT);
            if (in_valid && in_ready) begin
               accept     = 1'b1;
               state_next = EXEC;
            end
         end
         EXEC: begin
            push       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Division by zero is screened here so the ALU's output for it never matters.
   assign div_zero    = ((op_reg == OP_DIV) || (op_reg == OP_MOD)) && (b_reg == '0);
   assign push_result = div_zero ? '0 : alu_result;
   assign push_flags  = div_zero ? 4'b0001
                                 : {alu_overflow, alu_carryout, alu_negative, alu_zero};

   assign out_valid = (count_reg != '0);
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= IDLE;
         a_reg      <= '0;
         b_reg      <= '0;
         op_reg     <= '0;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         sticky_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            a_reg  <= in_a;
            b_reg  <= in_b;
            op_reg <= in_opcode;
         end
         if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
         if (push && push_flags[3]) sticky_reg <= 1'b1;
         else if (clr_sticky)       sticky_reg <= 1'b0;
      end
   end

   // Storage needs no reset: an entry is only ever read while count marks it live.
   always_ff @(posedge clk) begin
      if (push) begin
         res_mem[wr_ptr_reg]  <= push_result;
         flag_mem[wr_ptr_reg] <= push_flags;
         err_mem[wr_ptr_reg]  <= div_zero;
      end
   end

   assign out_result = out_valid ? res_mem[rd_ptr_reg]  : '0;
   assign out_flags  = out_valid ? flag_mem[rd_ptr_reg] : 4'b0000;
   assign out_err    = out_valid ? err_mem[rd_ptr_reg]  : 1'b0;

   assign alu_a      = a_reg;
   assign alu_b      = b_reg;
   assign alu_opcode = op_reg;
   assign sticky_ovf = sticky_reg;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: behavioural ALU, queue-based scoreboard, directed plus random traffic.
module tb_alu_issue;

   localparam int DEPTH = 4;

   typedef struct {
      logic [31:0] result;
      logic [3:0]  flags;
      logic        err;
   } entry_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, out_valid, out_ready, out_err, sticky_ovf, clr_sticky;
   logic [3:0]  in_opcode, alu_opcode, out_flags;
   logic [31:0] in_a, in_b, alu_a, alu_b, alu_result, out_result;
   logic        alu_zero, alu_negative, alu_carryout, alu_overflow;

   logic        in_valid8, in_ready8, out_valid8, out_ready8, out_err8, sticky8;
   logic [3:0]  in_opcode8, alu_opcode8, out_flags8;
   logic [7:0]  in_a8, in_b8, alu_a8, alu_b8, alu_result8, out_result8;
   logic [8:0]  sum8;

   int pass_cnt = 0;
   int total_cnt = 0;

   entry_t      m_q[$];
   bit          m_busy = 0;
   bit          m_sticky = 0;
   logic [3:0]  m_op;
   logic [31:0] m_a, m_b;

   logic [3:0]  c_op [3] = '{4'd9, 4'd11, 4'd8};
   logic [31:0] c_a  [3] = '{32'd4, 32'd4, 32'd3};
   logic [31:0] c_b  [3] = '{32'd2, 32'd3, 32'd10};

   always #5 clk = ~clk;

   alu_issue #(.WIDTH(32), .DEPTH(DEPTH)) u_dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
      .alu_zero(alu_zero), .alu_negative(alu_negative), .alu_carryout(alu_carryout),
      .alu_overflow(alu_overflow),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_flags(out_flags), .out_err(out_err), .sticky_ovf(sticky_ovf), .clr_sticky(clr_sticky)
   );

   alu_issue #(.WIDTH(8), .DEPTH(2)) u_dut8 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid8), .in_ready(in_ready8), .in_opcode(in_opcode8), .in_a(in_a8), .in_b(in_b8),
      .alu_a(alu_a8), .alu_b(alu_b8), .alu_opcode(alu_opcode8), .alu_result(alu_result8),
      .alu_zero(alu_result8 == 8'd0), .alu_negative(alu_result8[7]), .alu_carryout(sum8[8]),
      .alu_overflow((alu_a8[7] == alu_b8[7]) && (alu_result8[7] != alu_a8[7])),
      .out_valid(out_valid8), .out_ready(out_ready8), .out_result(out_result8),
      .out_flags(out_flags8), .out_err(out_err8), .sticky_ovf(sticky8), .clr_sticky(1'b0)
   );

   // Minimal 8-bit adder-only ALU for the narrow-width instance.
   assign sum8        = {1'b0, alu_a8} + {1'b0, alu_b8};
   assign alu_result8 = (alu_opcode8 == 4'b0110) ? sum8[7:0] : 8'd0;

   // Reference ALU: returns {result, overflow, carry, negative, zero}.
   function automatic logic [35:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      logic [31:0] r;
      logic        c, v;
      s = '0; r = '0; c = 1'b0; v = 1'b0;
      case (op)
         4'd0:  r = a & b;
         4'd1:  r = a | b;
         4'd2:  r = a ^ b;
         4'd3:  r = ~(a | b);
         4'd4:  r = ~(a & b);
         4'd5:  r = ~a;
         4'd6: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[31:0]; c = s[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         4'd7: begin
            s = {1'b0, a} + {1'b0, ~b} + 33'd1;
            r = s[31:0]; c = s[32];
            v = (a[31] != b[31]) && (r[31] != a[31]);
         end
         4'd8:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd9:  r = a * b;
         4'd10: r = (b == 0) ? 32'hFFFF_FFFF : 32'($signed(a) / $signed(b));
         4'd11: r = (b == 0) ? 32'hFFFF_FFFF : 32'($signed(a) % $signed(b));
         4'd12: r = a << b[4:0];
         4'd13: r = 32'($signed(a) >>> b[4:0]);
         default: r = 32'd0;
      endcase
      return {r, v, c, r[31], (r == 32'd0)};
   endfunction

   logic [35:0] alu_out;
   assign alu_out = alu_fn(alu_opcode, alu_a, alu_b);
   assign alu_result = alu_out[35:4];
   assign {alu_overflow, alu_carryout, alu_negative, alu_zero} = alu_out[3:0];

   // What the stage should deliver for one request, from the request alone.
   function automatic entry_t ref_entry(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      entry_t      e;
      logic [35:0] f;
      if ((op == 4'd10 || op == 4'd11) && b == 32'd0) begin
         e.result = 32'd0; e.flags = 4'b0001; e.err = 1'b1;
      end else begin
         f = alu_fn(op, a, b);
         e.result = f[35:4]; e.flags = f[3:0]; e.err = 1'b0;
      end
      return e;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Compare DUT against the model for this cycle, advance the model across the edge.
   task automatic tick(output bit acc);
      entry_t e;
      bit     exp_ready;
      exp_ready = !m_busy && (m_q.size() < DEPTH);
      acc = in_valid && exp_ready;
      check("in_ready", 64'(in_ready), 64'(exp_ready));
      check("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
      check("sticky_ovf", 64'(sticky_ovf), 64'(m_sticky));
      if (m_q.size() != 0)
         check("head", {out_result, out_flags, out_err}, {m_q[0].result, m_q[0].flags, m_q[0].err});
      else
         check("empty_head", {out_result, out_flags, out_err}, 64'd0);
      if (m_busy)
         check("alu_inputs", {alu_opcode, alu_a, alu_b}, {m_op, m_a, m_b});
      if (out_ready && m_q.size() != 0) void'(m_q.pop_front());
      if (m_busy) begin
         e = ref_entry(m_op, m_a, m_b);
         m_q.push_back(e);
         m_busy = 0;
         if (e.flags[3]) m_sticky = 1;
         else if (clr_sticky) m_sticky = 0;
      end else if (clr_sticky) begin
         m_sticky = 0;
      end
      if (acc) begin
         m_busy = 1; m_op = in_opcode; m_a = in_a; m_b = in_b;
      end
      @(posedge clk); #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      bit acc;
      bit done;
      done = 0;
      in_valid = 1'b1; in_opcode = op; in_a = a; in_b = b;
      for (int i = 0; i < 20 && !done; i++) begin
         tick(acc);
         if (acc) done = 1;
      end
      in_valid = 1'b0;
      check("issue_accepted", 64'(done), 64'd1);
   endtask

   task automatic run(input int n);
      bit acc;
      for (int i = 0; i < n; i++) tick(acc);
   endtask

   initial begin
      bit acc;
      int naccept;
      reset = 1'b1;
      in_valid = 0; in_opcode = 0; in_a = 0; in_b = 0; out_ready = 0; clr_sticky = 0;
      in_valid8 = 0; in_opcode8 = 0; in_a8 = 0; in_b8 = 0; out_ready8 = 0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_alu_regs", {alu_opcode, alu_a, alu_b}, 64'd0);
      check("rst_head", {out_result, out_flags, out_err, sticky_ovf}, 64'd0);

      // 8-bit instance: 127 + 1 overflows to 0x80
      in_valid8 = 1; in_opcode8 = 4'b0110; in_a8 = 8'd127; in_b8 = 8'd1;
      @(posedge clk); #1 in_valid8 = 0;
      check("w8_in_ready_exec", 64'(in_ready8), 64'd0);
      @(posedge clk); #1;
      check("w8_out_valid", 64'(out_valid8), 64'd1);
      check("w8_result", 64'(out_result8), 64'h80);
      check("w8_flags", {out_flags8, out_err8, sticky8}, {4'b1010, 1'b0, 1'b1});

      // ADD overflow and sticky clear
      out_ready = 1;
      issue(4'b0110, 32'h7FFF_FFFF, 32'd1);
      tick(acc);
      check("addovf_result", 64'(out_result), 64'h8000_0000);
      check("addovf_ovf_neg", {out_flags[3], out_flags[1], sticky_ovf}, 64'b111);
      clr_sticky = 1; tick(acc); clr_sticky = 0;
      check("sticky_cleared", 64'(sticky_ovf), 64'd0);

      // Divide by zero, then a legal divide
      issue(4'b1010, 32'd10, 32'd0);
      tick(acc);
      check("div0_head", {out_result, out_flags, out_err}, {32'd0, 4'b0001, 1'b1});
      issue(4'b1010, 32'd10, 32'd5);
      tick(acc);
      check("div_head", {out_result, out_err}, {32'd2, 1'b0});
      run(3);

      // Backpressure: five SUB 5-4 requests against a stalled output
      out_ready = 0;
      in_valid = 1; in_opcode = 4'b0111; in_a = 32'd5; in_b = 32'd4;
      naccept = 0;
      for (int i = 0; i < 12; i++) begin tick(acc); if (acc) naccept++; end
      check("bp_accepted", 64'(naccept), 64'd4);
      check("bp_in_ready_full", 64'(in_ready), 64'd0);
      out_ready = 1;
      for (int i = 0; i < 12 && naccept < 5; i++) begin tick(acc); if (acc) naccept++; end
      in_valid = 0;
      check("bp_fifth", 64'(naccept), 64'd5);
      run(8);

      // Concurrent push/pop holding two entries, wrapping pointers
      out_ready = 0;
      issue(4'b0110, 32'd1, 32'd2);
      issue(4'b0110, 32'd3, 32'd4);
      tick(acc);
      naccept = 0;
      for (int i = 0; i < 60 && naccept < 9; i++) begin
         out_ready = m_busy;
         in_valid = 1; in_opcode = c_op[naccept % 3]; in_a = c_a[naccept % 3]; in_b = c_b[naccept % 3];
         tick(acc);
         if (acc) naccept++;
      end
      in_valid = 0;
      out_ready = m_busy;
      tick(acc);
      check("conc_issued", 64'(naccept), 64'd9);
      check("conc_out_valid", 64'(out_valid), 64'd1);
      out_ready = 1;
      run(6);

      // Reset during EXEC drops the in-flight op
      issue(4'b0000, 32'd1, 32'd0);
      reset = 1;
      m_busy = 0; m_q.delete(); m_sticky = 0;
      @(posedge clk); #1 reset = 0;
      check("rstexec_out_valid", 64'(out_valid), 64'd0);
      check("rstexec_opcode", 64'(alu_opcode), 64'd0);
      check("rstexec_in_ready", 64'(in_ready), 64'd1);
      run(4);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         in_valid   = 1'($urandom_range(0, 1));
         in_opcode  = 4'($urandom_range(0, 15));
         in_a       = $urandom;
         in_b       = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
         out_ready  = ($urandom_range(0, 2) != 0);
         clr_sticky = ($urandom_range(0, 7) == 0);
         tick(acc);
      end
      in_valid = 0; clr_sticky = 0; out_ready = 1;
      run(8);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
